// File: rtl/risc_pkg.sv
// Shared definitions for the 13-bit RISC core: widths, NOP encoding, opcode field, imem states.
package risc_pkg;

  localparam int unsigned IW = 13;
  localparam int unsigned AW = 5;

  localparam logic [IW-1:0] Nop = 13'h0000;

  localparam int unsigned OpMsb = 12;
  localparam int unsigned OpLsb = 9;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } imem_state_e;

endpackage

// File: rtl/risc_imem_if.sv
// Loader and fetch signals between the instruction memory and its users.
interface risc_imem_if #(
  parameter int unsigned IW = risc_pkg::IW,
  parameter int unsigned AW = risc_pkg::AW
);

  logic          load_start;
  logic          ld_valid;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic [AW:0]   ld_count;
  logic [AW-1:0] pc;
  logic [IW-1:0] instruction;
  logic          iu_hold;
  logic          fetch_err;

  // Memory side
  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, pc,
    output ld_ready, ld_count, instruction, iu_hold, fetch_err
  );

  // Loader / instruction-unit side
  modport master (
    output load_start, ld_valid, ld_data, ld_last, pc,
    input  ld_ready, ld_count, instruction, iu_hold, fetch_err
  );

endinterface

// File: rtl/risc_imem_array.sv
// 2**AW x IW register file: async clear, one write port, one combinational read port.
module risc_imem_array #(
  parameter int unsigned IW = risc_pkg::IW,
  parameter int unsigned AW = risc_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [2**AW];

  // Storage: whole array clears on reset so a partial program never survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/risc_imem.sv
// Instruction memory: program loader FSM plus registered fetch port for risc_iunit.
module risc_imem #(
  parameter int unsigned IW = risc_pkg::IW,
  parameter int unsigned AW = risc_pkg::AW
) (
  input  logic        clk,
  input  logic        rst_n,
  risc_imem_if.slave  bus
);

  import risc_pkg::*;

  // Count value whose transfer fills the last slot
  localparam logic [AW:0] LastSlot = (AW+1)'((1 << AW) - 1);

  imem_state_e   state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          err_q, err_d;
  logic          wr_en;
  logic          in_range;
  logic [IW-1:0] rd_data;

  risc_imem_array #(
    .IW (IW),
    .AW (AW)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (bus.ld_data),
    .raddr_i (bus.pc),
    .rdata_o (rd_data)
  );

  // Only words actually loaded are served
  assign in_range = {1'b0, bus.pc} < count_q;

  // Next-state, write enable and fetch result
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    instr_d = IW'(Nop);
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load_start) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      StLoad: begin
        // load_start is ignored here, including on the final transfer
        if (bus.ld_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (bus.ld_last || (count_q == LastSlot)) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (in_range) begin
          instr_d = rd_data;
        end else begin
          err_d = 1'b1;
        end
        if (bus.load_start) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign bus.ld_ready    = (state_q == StLoad);
  assign bus.iu_hold     = (state_q != StRun);
  assign bus.ld_count    = count_q;
  assign bus.instruction = instr_q;
  assign bus.fetch_err   = err_q;

endmodule
